// File: rtl/vga_tile_palette_pkg.sv
// vga_tile_palette_pkg: CTRL bit positions, register index helpers and colour packing for the tile palette.
package vga_tile_palette_pkg;
  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_AUTO = 1;
  function automatic int border_idx(input int n);
    return n;
  endfunction
  function automatic int ctrl_idx(input int n);
    return n + 1;
  endfunction
  function automatic logic [63:0] pack_rgb(input int ch_w, input logic [20:0] r, input logic [20:0] g, input logic [20:0] b);
    return (64'(r) << (2 * ch_w)) | (64'(g) << ch_w) | 64'(b);
  endfunction
endpackage

// File: rtl/vga_tile_palette_lookup.sv
// vga_tile_palette_lookup: two-stage pixel pipeline, coordinate -> tile index -> registered colour.
module vga_tile_palette_lookup
  import vga_tile_palette_pkg::*;
#(
  parameter int CH_W = 10,
  parameter int GRID_X_LOG2 = 2,
  parameter int GRID_Y_LOG2 = 2,
  parameter int TILE_W_LOG2 = 7,
  parameter int TILE_H_LOG2 = 7,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  localparam int N = (1 << GRID_X_LOG2) * (1 << GRID_Y_LOG2),
  localparam int CW = 3 * CH_W,
  localparam int IW = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         pix_x,
  input  logic [15:0]         pix_y,
  input  logic [N:0][CW-1:0]  active,
  output logic [CW-1:0]       colour
);
  logic [15:0] col_full, row_full;
  logic [GRID_X_LOG2-1:0] col;
  logic [GRID_Y_LOG2-1:0] row;
  logic border, border_c;
  logic [IW-1:0] idx;
  assign col_full = pix_x >> TILE_W_LOG2;
  assign row_full = pix_y >> TILE_H_LOG2;
  assign border_c = pix_x >= 16'(H_RES) || pix_y >= 16'(V_RES) ||
                    col_full >= 16'(1 << GRID_X_LOG2) || row_full >= 16'(1 << GRID_Y_LOG2);
  assign idx = border ? IW'(border_idx(N)) : IW'({row, col});
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      border <= 1'b0;
      colour <= '0;
    end else begin
      col <= col_full[GRID_X_LOG2-1:0];
      row <= row_full[GRID_Y_LOG2-1:0];
      border <= border_c;
      colour <= active[idx];
    end
  end
endmodule

// File: rtl/vga_tile_palette.sv
// vga_tile_palette: double-buffered tile colour map with bus access and frame-synchronous commit.
module vga_tile_palette
  import vga_tile_palette_pkg::*;
#(
  parameter int CH_W = 10,
  parameter int GRID_X_LOG2 = 2,
  parameter int GRID_Y_LOG2 = 2,
  parameter int TILE_W_LOG2 = 7,
  parameter int TILE_H_LOG2 = 7,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       cr,
  output logic [31:0]       rd_data,
  input  logic              frame_start,
  input  logic [15:0]       pix_x,
  input  logic [15:0]       pix_y,
  output logic [CH_W-1:0]   r,
  output logic [CH_W-1:0]   g,
  output logic [CH_W-1:0]   b,
  output logic              pending
);
  localparam int N = (1 << GRID_X_LOG2) * (1 << GRID_Y_LOG2);
  localparam int CW = 3 * CH_W;
  localparam int IW = $clog2(N + 1);
  logic [N:0][CW-1:0] shadow, active;
  logic [CW-1:0] colour;
  logic [IW-1:0] a;
  logic auto_mode, tile_wr, ctrl_wr, set_pend, copy;
  logic [31:0] rd_next;
  logic unused_bits;
  assign unused_bits = ^cr[31:CW];
  assign a = addr[IW-1:0];
  assign tile_wr = write && addr <= ADDR_W'(border_idx(N));
  assign ctrl_wr = write && addr == ADDR_W'(ctrl_idx(N));
  assign set_pend = (ctrl_wr && cr[CTRL_COMMIT]) || (tile_wr && auto_mode);
  // A write that sets pending in the same cycle as frame start still triggers a copy, but of the old shadow.
  assign copy = frame_start && (pending || set_pend);
  always_comb begin
    rd_next = '0;
    rd_next = addr <= ADDR_W'(border_idx(N)) ? 32'(shadow[a]) :
              addr == ADDR_W'(ctrl_idx(N)) ? {30'b0, auto_mode, pending} : 32'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
      auto_mode <= 1'b0;
      pending <= 1'b0;
      rd_data <= '0;
    end else begin
      if (tile_wr) shadow[a] <= cr[CW-1:0];
      if (ctrl_wr) auto_mode <= cr[CTRL_AUTO];
      if (copy) active <= shadow;
      pending <= set_pend || (pending && !frame_start);
      rd_data <= rd_next;
    end
  end
  vga_tile_palette_lookup #(
    .CH_W(CH_W), .GRID_X_LOG2(GRID_X_LOG2), .GRID_Y_LOG2(GRID_Y_LOG2),
    .TILE_W_LOG2(TILE_W_LOG2), .TILE_H_LOG2(TILE_H_LOG2), .H_RES(H_RES), .V_RES(V_RES)
  ) u_lookup (
    .clk(clk),
    .rst(rst),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .active(active),
    .colour(colour)
  );
  assign {r, g, b} = colour;
endmodule
